// File: rtl/rect_fill_writer.sv
// Rectangle fill generator: clips a rectangle to the frame and streams one pixel write per cycle.
// Optional macro RECT_OUTLINE_EN adds an `outline` input that restricts writes to the border.
module rect_fill_writer #(
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         x0,
    input  logic [9:0]         y0,
    input  logic [9:0]         w,
    input  logic [9:0]         h,
    input  logic [COLOR_W-1:0] color,
    input  logic               stall,
`ifdef RECT_OUTLINE_EN
    input  logic               outline,
`endif
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               wr_en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, FINISH} state_t;

    state_t             state_reg;
    logic [9:0]         x0_reg, y0_reg, w_reg, h_reg;
    logic [COLOR_W-1:0] color_reg;
    logic [9:0]         x_reg, y_reg, x_end_reg, y_end_reg;
    logic [ADDR_W-1:0]  row_base_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [COLOR_W-1:0] wr_data_reg;
    logic               wr_en_reg, busy_reg, done_reg;
    logic               outline_active;

`ifdef RECT_OUTLINE_EN
    logic outline_reg;
    assign outline_active = outline_reg;
`else
    assign outline_active = 1'b0;
`endif

    // Clip arithmetic: 11-bit sums so x0+w cannot wrap before the compare.
    logic [10:0]       x_sum, y_sum;
    logic [9:0]        x_end_c, y_end_c;
    logic              empty_c;
    logic [ADDR_W-1:0] row_base_c;

    assign x_sum      = {1'b0, x0_reg} + {1'b0, w_reg};
    assign y_sum      = {1'b0, y0_reg} + {1'b0, h_reg};
    assign x_end_c    = (x_sum > 11'(FB_W)) ? 10'(FB_W - 1) : 10'(x_sum - 11'd1);
    assign y_end_c    = (y_sum > 11'(FB_H)) ? 10'(FB_H - 1) : 10'(y_sum - 11'd1);
    assign empty_c    = (w_reg == 10'd0) || (h_reg == 10'd0) ||
                        (x0_reg >= 10'(FB_W)) || (y0_reg >= 10'(FB_H));
    assign row_base_c = ADDR_W'(y0_reg) * ADDR_W'(FB_W);

    // Walk control; interior outline rows skip straight from the left to the right edge.
    logic              last_col, last_row, border_row, jump_c;
    logic [ADDR_W-1:0] pix_addr;

    assign last_col   = (x_reg == x_end_reg);
    assign last_row   = (y_reg == y_end_reg);
    assign border_row = (y_reg == y0_reg) || last_row;
    assign jump_c     = outline_active && !border_row && (x_reg == x0_reg) && !last_col;
    assign pix_addr   = row_base_reg + ADDR_W'(x_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            color_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            x_end_reg    <= '0;
            y_end_reg    <= '0;
            row_base_reg <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            wr_en_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef RECT_OUTLINE_EN
            outline_reg  <= 1'b0;
`endif
        end else begin
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x0_reg    <= x0;
                        y0_reg    <= y0;
                        w_reg     <= w;
                        h_reg     <= h;
                        color_reg <= color;
`ifdef RECT_OUTLINE_EN
                        outline_reg <= outline;
`endif
                        busy_reg  <= 1'b1;
                        state_reg <= CLIP;
                    end
                end
                CLIP: begin
                    if (empty_c) begin
                        state_reg <= FINISH;
                    end else begin
                        x_reg        <= x0_reg;
                        y_reg        <= y0_reg;
                        x_end_reg    <= x_end_c;
                        y_end_reg    <= y_end_c;
                        row_base_reg <= row_base_c;
                        state_reg    <= FILL;
                    end
                end
                FILL: begin
                    if (!stall) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= pix_addr;
                        wr_data_reg <= color_reg;
                        if (last_col && last_row) begin
                            state_reg <= FINISH;
                        end else if (last_col) begin
                            x_reg        <= x0_reg;
                            y_reg        <= y_reg + 10'd1;
                            row_base_reg <= row_base_reg + ADDR_W'(FB_W);
                        end else if (jump_c) begin
                            x_reg <= x_end_reg;
                        end else begin
                            x_reg <= x_reg + 10'd1;
                        end
                    end
                end
                FINISH: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign wr_en   = wr_en_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer: solid fill, clipping, empty rectangles, stall, reset, outline.
module tb_rect_fill_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  x0 = '0, y0 = '0, w = '0, h = '0;
    logic [23:0] color = '0;
    logic        stall = 1'b0;
    logic        outline = 1'b0;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_en, busy, done;

    rect_fill_writer #(.FB_W(160), .FB_H(120), .ADDR_W(15), .COLOR_W(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x0      (x0),
        .y0      (y0),
        .w       (w),
        .h       (h),
        .color   (color),
        .stall   (stall),
`ifdef RECT_OUTLINE_EN
        .outline (outline),
`endif
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        busy_at_done = 1'b0;
    int          addr_q[$];
    logic [23:0] data_q[$];
    int          wcyc_q[$];
    int          exp_addr[$];
    int          exp_cyc[$];
    int          exp_done;
    logic [23:0] exp_col;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Monitor samples 1 ns after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (wr_en) begin
            addr_q.push_back(int'(wr_addr));
            data_q.push_back(wr_data);
            wcyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        addr_q.delete();
        data_q.delete();
        wcyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic issue_start(input int ax0, input int ay0, input int aw, input int ah,
                               input logic [23:0] col);
        x0 = 10'(ax0);
        y0 = 10'(ay0);
        w = 10'(aw);
        h = 10'(ah);
        color = col;
        start = 1'b1;
        @(posedge clk);
        #2;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic run_fill(input int ax0, input int ay0, input int aw, input int ah,
                            input logic [23:0] col, input int stall_after, input int stall_len);
        bit stalled = 0;
        clear_obs();
        issue_start(ax0, ay0, aw, ah, col);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > 0) break;
            @(posedge clk);
            #2;
            if (!stalled && stall_len > 0 && addr_q.size() == stall_after) begin
                stall = 1'b1;
                repeat (stall_len) begin
                    @(posedge clk);
                    #2;
                end
                stall = 1'b0;
                stalled = 1;
            end
        end
        repeat (3) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic verify(input string name);
        int n;
        check_value({name, "_count"}, addr_q.size(), exp_addr.size());
        n = (addr_q.size() < exp_addr.size()) ? addr_q.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check_value($sformatf("%s_addr%0d", name, i), addr_q[i], exp_addr[i]);
            check_value($sformatf("%s_data%0d", name, i), data_q[i], exp_col);
            check_value($sformatf("%s_cyc%0d", name, i), wcyc_q[i] - start_cyc, exp_cyc[i]);
        end
        check_value({name, "_done_pulses"}, done_cnt, 1);
        if (done_cnt > 0) begin
            check_value({name, "_done_cyc"}, done_cyc - start_cyc, exp_done);
            check_value({name, "_busy_at_done"}, busy_at_done, 0);
        end
        $display("%s: %0d writes, done at start+%0d", name, addr_q.size(),
                 (done_cnt > 0) ? done_cyc - start_cyc : -1);
    endtask

    task automatic seq_cycles(input int first, input int count);
        exp_cyc.delete();
        for (int i = 0; i < count; i++) exp_cyc.push_back(first + i);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_value("reset_wr_en", wr_en, 0);
        check_value("reset_wr_addr", wr_addr, 0);
        check_value("reset_wr_data", wr_data, 0);
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Solid 3x2 fill at (10,5)
        exp_addr = '{810, 811, 812, 970, 971, 972};
        seq_cycles(2, 6);
        exp_done = 8;
        exp_col = 24'hFF0000;
        run_fill(10, 5, 3, 2, 24'hFF0000, 0, 0);
        verify("solid");

        // Busy is high one cycle after start acceptance
        clear_obs();
        issue_start(20, 20, 1, 1, 24'h123456);
        check_value("busy_after_start", busy, 1);
        repeat (5) begin
            @(posedge clk);
            #2;
        end
        check_value("single_pixel_addr", (addr_q.size() == 1) ? addr_q[0] : -1, 20 * 160 + 20);

        // Clipped at the bottom-right corner
        exp_addr = '{19198, 19199};
        seq_cycles(2, 2);
        exp_done = 4;
        exp_col = 24'h00FF00;
        run_fill(158, 119, 5, 4, 24'h00FF00, 0, 0);
        verify("clip");

        // Empty rectangles
        exp_addr.delete();
        exp_cyc.delete();
        exp_done = 2;
        exp_col = 24'h0000FF;
        run_fill(10, 5, 0, 2, 24'h0000FF, 0, 0);
        verify("w_zero");
        run_fill(160, 5, 3, 2, 24'h0000FF, 0, 0);
        verify("x_off");
        run_fill(10, 120, 3, 2, 24'h0000FF, 0, 0);
        verify("y_off");

        // Stall for 4 cycles after the second write
        exp_addr = '{810, 811, 812, 970, 971, 972};
        exp_cyc = '{2, 3, 8, 9, 10, 11};
        exp_done = 12;
        exp_col = 24'hFF0000;
        run_fill(10, 5, 3, 2, 24'hFF0000, 2, 4);
        verify("stall");

        // Restart ignored mid-fill, then reset aborts the fill
        clear_obs();
        issue_start(10, 5, 3, 2, 24'hABCDEF);
        for (int i = 0; i < 20 && addr_q.size() < 1; i++) begin
            @(posedge clk);
            #2;
        end
        x0 = 10'd0; y0 = 10'd0; w = 10'd5; h = 10'd5; color = 24'h111111;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int i = 0; i < 20 && addr_q.size() < 3; i++) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_value("rst_wr_en", wr_en, 0);
        check_value("rst_busy", busy, 0);
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        check_value("rst_no_done", done_cnt, 0);
        check_value("rst_write_count", addr_q.size(), 3);
        for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
            check_value($sformatf("restart_addr%0d", i), addr_q[i], 810 + i);
            check_value($sformatf("restart_data%0d", i), data_q[i], 24'hABCDEF);
        end
        $display("reset_abort: %0d writes before reset, %0d done pulses", addr_q.size(), done_cnt);

        exp_addr = '{810, 811, 812, 970, 971, 972};
        seq_cycles(2, 6);
        exp_done = 8;
        exp_col = 24'h00FFFF;
        run_fill(10, 5, 3, 2, 24'h00FFFF, 0, 0);
        verify("after_rst");

`ifdef RECT_OUTLINE_EN
        outline = 1'b1;
        exp_addr = '{0, 1, 2, 3, 160, 163, 320, 321, 322, 323};
        seq_cycles(2, 10);
        exp_done = 12;
        exp_col = 24'h808080;
        run_fill(0, 0, 4, 3, 24'h808080, 0, 0);
        verify("outline");
        outline = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
